tff_bank_counter: RTL and testbench

//   WIDTH-bit bank of T flip-flops with a shared clock and a run-time mode.

---
 rtl/tff_bank_pkg.sv | 13 +
 rtl/tff_bank_chk.sv | 14 +
 rtl/tff_cell.sv | 28 ++
 rtl/tff_bank_counter.sv | 115 +++++++++++
 tb/tb_tff_bank_counter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/tff_bank_pkg.sv
// Shared types for the T flip-flop bank counter: run-time mode encoding and its width.
package tff_bank_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } tff_mode_t;

endpackage

// File: rtl/tff_bank_chk.sv
// Simulation checker for the bank counter: mode must be known whenever a step is enabled.
module tff_bank_chk
  import tff_bank_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  input logic              en,
  input logic [MODE_W-1:0] mode
);

  a_mode_known: assert property (@(posedge clk) disable iff (!rst_n) en |-> !$isunknown(mode))
    else $error("tff_bank_chk: mode is X/Z while en=1");

endmodule

// File: rtl/tff_cell.sv
// Single T flip-flop with async reset to a per-instance value and a synchronous load that beats t.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic ld,
  input  logic ld_d,
  input  logic t,
  output logic q
);

  logic q_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= rst_val;
    end else if (ld) begin
      q_r <= ld_d;
    end else if (t) begin
      q_r <= ~q_r;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/tff_bank_counter.sv
// WIDTH-bit bank of T cells: hold, per-bit toggle, up or down count via a carry/borrow T-chain.
// Optional macro TFF_BANK_SAT_EN makes counting saturate at the terminal value instead of wrapping.
module tff_bank_counter
  import tff_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  tff_mode_t        mode,
  input  logic [WIDTH-1:0] t_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             tc_evt
);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] carry_s;
  logic [WIDTH-1:0] borrow_s;
  logic [WIDTH-1:0] t_vec_s;
  logic [WIDTH-1:0] t_cell_s;
  logic             count_s;
  logic             tc_s;
  logic             tc_evt_r;

  // T[i] is the AND of all lower bits (up) or of all lower inverted bits (down).
  always_comb begin
    carry_s     = {WIDTH{1'b0}};
    borrow_s    = {WIDTH{1'b0}};
    carry_s[0]  = 1'b1;
    borrow_s[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      carry_s[i]  = carry_s[i-1] & q_s[i-1];
      borrow_s[i] = borrow_s[i-1] & ~q_s[i-1];
    end
  end

  always_comb begin
    t_vec_s = {WIDTH{1'b0}};
    count_s = 1'b0;
    tc_s    = 1'b0;
    case (mode)
      MODE_TOGGLE: begin
        t_vec_s = t_in;
      end
      MODE_UP: begin
        t_vec_s = carry_s;
        count_s = 1'b1;
        tc_s    = &q_s;
      end
      MODE_DOWN: begin
        t_vec_s = borrow_s;
        count_s = 1'b1;
        tc_s    = ~|q_s;
      end
      default: begin
        t_vec_s = {WIDTH{1'b0}};
      end
    endcase
  end

  always_comb begin
    t_cell_s = {WIDTH{1'b0}};
    if (!en) begin
      t_cell_s = {WIDTH{1'b0}};
`ifdef TFF_BANK_SAT_EN
    end else if (count_s && tc_s) begin
      t_cell_s = {WIDTH{1'b0}};
`endif
    end else begin
      t_cell_s = t_vec_s;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (RST_VAL[g]),
      .ld      (load),
      .ld_d    (load_val[g]),
      .t       (t_cell_s[g]),
      .q       (q_s[g])
    );
  end

  // Pulse on every counting step taken at terminal count (the wrap, or a blocked step when saturating).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_evt_r <= 1'b0;
    end else if (load) begin
      tc_evt_r <= 1'b0;
    end else if (en && count_s && tc_s) begin
      tc_evt_r <= 1'b1;
    end else begin
      tc_evt_r <= 1'b0;
    end
  end

  tff_bank_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode)
  );

  assign q      = q_s;
  assign tc     = tc_s;
  assign tc_evt = tc_evt_r;

endmodule

// File: tb/tb_tff_bank_counter.sv
// Directed self-checking bench for tff_bank_counter (WIDTH=4, RST_VAL=4'h3).
module tb_tff_bank_counter;
  import tff_bank_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  tff_mode_t  mode;
  logic [3:0] t_in;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc;
  logic       tc_evt;

  int passed;
  int total;

  tff_bank_counter #(.WIDTH(4), .RST_VAL(4'h3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_in(t_in),
    .load(load), .load_val(load_val), .q(q), .tc(tc), .tc_evt(tc_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (q !== 4'h3) $display("FAIL reset_q got=%h exp=%h", q, 4'h3); else passed++;
    total++;
    if (tc_evt !== 1'b0) $display("FAIL reset_tc_evt got=%b exp=%b", tc_evt, 1'b0); else passed++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (q !== 4'h3) $display("FAIL hold_q got=%h exp=%h", q, 4'h3); else passed++;
    total++;
    if (tc !== 1'b0) $display("FAIL hold_tc got=%b exp=%b", tc, 1'b0); else passed++;
  endtask

  task automatic test_toggle();
    mode = MODE_TOGGLE; en = 1'b1; t_in = 4'b1010;
    step();
    total++;
    if (q !== 4'b1001) $display("FAIL toggle1_q got=%b exp=%b", q, 4'b1001); else passed++;
    total++;
    if (tc !== 1'b0) $display("FAIL toggle1_tc got=%b exp=%b", tc, 1'b0); else passed++;
    step();
    total++;
    if (q !== 4'b0011) $display("FAIL toggle2_q got=%b exp=%b", q, 4'b0011); else passed++;
    total++;
    if (tc !== 1'b0 || tc_evt !== 1'b0) $display("FAIL toggle2_tc got=%b%b exp=00", tc, tc_evt); else passed++;
    t_in = 4'b0000; en = 1'b0;
  endtask

  task automatic test_up_wrap();
    load = 1'b1; load_val = 4'hE;
    step();
    load = 1'b0; en = 1'b1; mode = MODE_UP;
    #1;
    total++;
    if (q !== 4'hE || tc !== 1'b0) $display("FAIL up_load got q=%h tc=%b exp q=e tc=0", q, tc); else passed++;
    step();
    total++;
    if (q !== 4'hF || tc !== 1'b1 || tc_evt !== 1'b0)
      $display("FAIL up_f got q=%h tc=%b ev=%b exp q=f tc=1 ev=0", q, tc, tc_evt); else passed++;
`ifdef TFF_BANK_SAT_EN
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (q !== 4'hF || tc_evt !== 1'b1) $display("FAIL up_sat got q=%h ev=%b exp q=f ev=1", q, tc_evt); else passed++;
    end
`else
    step();
    total++;
    if (q !== 4'h0 || tc_evt !== 1'b1 || tc !== 1'b0)
      $display("FAIL up_wrap got q=%h tc=%b ev=%b exp q=0 tc=0 ev=1", q, tc, tc_evt); else passed++;
    step();
    total++;
    if (q !== 4'h1 || tc_evt !== 1'b0) $display("FAIL up_after got q=%h ev=%b exp q=1 ev=0", q, tc_evt); else passed++;
`endif
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    load = 1'b1; load_val = 4'h1;
    step();
    load = 1'b0; en = 1'b1; mode = MODE_DOWN;
    #1;
    total++;
    if (q !== 4'h1 || tc !== 1'b0) $display("FAIL down_load got q=%h tc=%b exp q=1 tc=0", q, tc); else passed++;
    step();
    total++;
    if (q !== 4'h0 || tc !== 1'b1 || tc_evt !== 1'b0)
      $display("FAIL down_0 got q=%h tc=%b ev=%b exp q=0 tc=1 ev=0", q, tc, tc_evt); else passed++;
    step();
`ifdef TFF_BANK_SAT_EN
    total++;
    if (q !== 4'h0 || tc_evt !== 1'b1) $display("FAIL down_sat got q=%h ev=%b exp q=0 ev=1", q, tc_evt); else passed++;
`else
    total++;
    if (q !== 4'hF || tc_evt !== 1'b1) $display("FAIL down_wrap got q=%h ev=%b exp q=f ev=1", q, tc_evt); else passed++;
`endif
    en = 1'b0;
    mode = MODE_HOLD;
    #1;
    total++;
    if (tc !== 1'b0) $display("FAIL hold_mode_tc got=%b exp=%b", tc, 1'b0); else passed++;
  endtask

  task automatic test_priority();
    load = 1'b1; load_val = 4'hF;
    step();
    load = 1'b0; mode = MODE_UP; en = 1'b0;
    #1;
    total++;
    if (tc !== 1'b1) $display("FAIL tc_no_en got=%b exp=%b", tc, 1'b1); else passed++;
    step();
    total++;
    if (q !== 4'hF || tc_evt !== 1'b0) $display("FAIL en_low_hold got q=%h ev=%b exp q=f ev=0", q, tc_evt); else passed++;
    load = 1'b1; load_val = 4'h5; en = 1'b1;
    step();
    total++;
    if (q !== 4'h5 || tc_evt !== 1'b0) $display("FAIL load_prio got q=%h ev=%b exp q=5 ev=0", q, tc_evt); else passed++;
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    load = 1'b1; load_val = 4'h9;
    step();
    load = 1'b0; en = 1'b1; mode = MODE_UP;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (q !== 4'h3 || tc_evt !== 1'b0) $display("FAIL midreset got q=%h ev=%b exp q=3 ev=0", q, tc_evt); else passed++;
    #1 rst_n = 1'b1;
    step();
    total++;
    if (q !== 4'h4) $display("FAIL after_release got=%h exp=%h", q, 4'h4); else passed++;
    en = 1'b0;
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b1; en = 1'b0; mode = MODE_HOLD; t_in = 4'h0; load = 1'b0; load_val = 4'h0;
    test_reset();
    test_toggle();
    test_up_wrap();
    test_down_wrap();
    test_priority();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
